// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned,
// with start/busy/done handshake and divide-by-zero / overflow flags.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] work_reg, work_next;
    logic [WIDTH-1:0]   absm_reg, absm_next;
    logic               sign_q_reg, sign_q_next;
    logic               sign_r_reg, sign_r_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [WIDTH-1:0]   quotient_reg, quotient_next;
    logic [WIDTH-1:0]   remainder_reg, remainder_next;
    logic               dbz_reg, dbz_next;
    logic               ovf_reg, ovf_next;

    logic               neg_a, neg_m;
    logic [WIDTH-1:0]   abs_a, abs_m;
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   q_raw, r_raw;

    assign neg_a = signed_mode & dividend[WIDTH-1];
    assign neg_m = signed_mode & divisor[WIDTH-1];
    assign abs_a = neg_a ? -dividend : dividend;
    assign abs_m = neg_m ? -divisor : divisor;

    // Upper half after the left shift, keeping the bit that shifts out so the
    // partial remainder (< 2|M|) never loses its MSB.
    assign partial = work_reg[2*WIDTH-1:WIDTH-1];
    assign diff    = partial - {1'b0, absm_reg};
    assign q_raw   = work_reg[WIDTH-1:0];
    assign r_raw   = work_reg[2*WIDTH-1:WIDTH];

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            work_reg      <= '0;
            absm_reg      <= '0;
            sign_q_reg    <= 1'b0;
            sign_r_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            work_reg      <= work_next;
            absm_reg      <= absm_next;
            sign_q_reg    <= sign_q_next;
            sign_r_reg    <= sign_r_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
            ovf_reg       <= ovf_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        work_next      = work_reg;
        absm_next      = absm_reg;
        sign_q_next    = sign_q_reg;
        sign_r_next    = sign_r_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        ovf_next       = ovf_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    absm_next   = abs_m;
                    sign_q_next = neg_a ^ neg_m;
                    sign_r_next = neg_a;
                    dbz_next    = 1'b0;
                    ovf_next    = 1'b0;
                    if (divisor == '0) begin
                        quotient_next  = '1;
                        remainder_next = dividend;
                        dbz_next       = 1'b1;
                        done_next      = 1'b1;
                    end else if (signed_mode && dividend == MOST_NEG && divisor == '1) begin
                        quotient_next  = MOST_NEG;
                        remainder_next = '0;
                        ovf_next       = 1'b1;
                        done_next      = 1'b1;
                    end else begin
                        busy_next  = 1'b1;
                        cnt_next   = CNT_W'(WIDTH);
                        work_next  = {{WIDTH{1'b0}}, abs_a};
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (!diff[WIDTH])
                    work_next = {diff[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1};
                else
                    work_next = {work_reg[2*WIDTH-2:0], 1'b0};
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1))
                    state_next = FIXUP;
            end
            FIXUP: begin
                quotient_next  = sign_q_reg ? -q_raw : q_raw;
                remainder_next = sign_r_reg ? -r_raw : r_raw;
                done_next      = 1'b1;
                busy_next      = 1'b0;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;
    assign overflow    = ovf_reg;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq at WIDTH=32: driver pushes expected results,
// a negedge monitor pops and compares whenever done is high.
module tb_div_seq;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic          signed_mode;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;
    logic          overflow;

    div_seq #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           exp_edge;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: one line per completed transaction.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (edge %0d)", edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", W'(div_by_zero), W'(e.dbz));
                chk("overflow", W'(overflow), W'(e.ovf));
                chk("busy_at_done", W'(busy), '0);
                chk("latency_edge", W'(edge_cnt), W'(e.exp_edge));
                $display("txn edge=%0d q=0x%08h r=0x%08h dbz=%0b ovf=%0b", edge_cnt, quotient,
                         remainder, div_by_zero, overflow);
            end
        end
    end

    // Called at a negedge: present operands, pulse start for one edge.
    task automatic issue(input logic sm, input logic [W-1:0] a, input logic [W-1:0] m,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input logic eovf, input bit special);
        exp_t e;
        signed_mode = sm;
        dividend    = a;
        divisor     = m;
        start       = 1'b1;
        e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
        e.exp_edge = edge_cnt + 1 + (special ? 0 : W + 1);
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    typedef struct {
        logic         sm;
        logic [W-1:0] a, m, q, r;
        logic         dbz, ovf;
        bit           special;
    } vec_t;

    vec_t vecs[$];

    initial begin
        clear = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
        @(negedge clock); @(negedge clock);
        chk("reset_busy", W'(busy), '0);
        chk("reset_done", W'(done), '0);
        chk("reset_quotient", quotient, '0);
        chk("reset_remainder", remainder, '0);
        clear = 1'b0;
        @(negedge clock);

        // Latency and busy window for 100/7.
        issue(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
        chk("busy_first", W'(busy), W'(1));
        repeat (W - 1) @(negedge clock);
        chk("busy_last", W'(busy), W'(1));
        drain();

        vecs.push_back('{1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFFFF9C, 32'd7,        32'h24924916, 32'd2,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'd123,      32'd0,        32'hFFFFFFFF, 32'd123,      1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 1'b0});
        foreach (vecs[i]) begin
            issue(vecs[i].sm, vecs[i].a, vecs[i].m, vecs[i].q, vecs[i].r,
                  vecs[i].dbz, vecs[i].ovf, vecs[i].special);
            if (vecs[i].special)
                chk("special_no_busy", W'(busy), '0);
            drain();
        end

        // Start while busy is ignored.
        issue(1'b0, 32'd27, 32'd5, 32'd5, 32'd2, 1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge clock);
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drain();

        // Back-to-back: new start in the done cycle.
        issue(1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 1'b0, 1'b0, 1'b0);
        begin
            int t = 0;
            while (done !== 1'b1 && t < 100) begin
                @(negedge clock);
                t++;
            end
            chk("b2b_done_seen", W'(done), W'(1));
        end
        issue(1'b0, 32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        drain();

        // Clear mid-operation aborts with no done pulse.
        start = 1'b1; signed_mode = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("clear_busy", W'(busy), '0);
        chk("clear_done", W'(done), '0);
        chk("clear_quotient", quotient, '0);
        chk("clear_remainder", remainder, '0);
        chk("clear_flags", W'({div_by_zero, overflow}), '0);
        repeat (W + 4) @(negedge clock);
        issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
